// File: rtl/dspl_scan_driver.sv
// dspl_scan_driver: time-multiplexed 8-digit common-anode 7-segment scan driver
// Ports: clock, reset (async active-low); d1..d8 digit words {en, hex[3:0], dp};
//        blink per-digit blink request (bit i-1 = d<i>, used only with DSPL_BLINK_EN);
//        an anodes active-low (an[7] = d1); dec_ddp segments active-low {a,b,c,d,e,f,g,dp}.
// Optional: define DSPL_BLINK_EN to flash digits whose blink bit is set.
module dspl_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    input  logic [7:0] blink,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);
    localparam int CMAX = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [6:0] SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    typedef enum logic {BLANK, DRIVE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] idx, idx_nx;
    logic [7:0] an_nx, ddp_nx;
    logic [47:0] words;
    logic [5:0] word;
    logic lit, frame_done;
    assign words = {d8, d7, d6, d5, d4, d3, d2, d1};
    assign word = words[idx*6 +: 6];
`ifdef DSPL_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] fcnt;
    logic phase;
    logic fwrap;
    assign fwrap = fcnt == FW'(BLINK_FRAMES - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (frame_done) begin
            fcnt  <= fwrap ? '0 : fcnt + 1'b1;
            phase <= fwrap ? ~phase : phase;
        end
    end
    // a blinking digit is treated as disabled during the off phase
    assign lit = word[5] & (phase | ~blink[idx]);
`else
    logic unused_blink;
    assign unused_blink = ^{blink, frame_done} ^ (BLINK_FRAMES != 0);
    assign lit = word[5];
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            an      <= 8'hFF;
            dec_ddp <= 8'hFF;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            an      <= an_nx;
            dec_ddp <= ddp_nx;
        end
    end
    // outputs only change on state edges, so a word is sampled once per slot
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        idx_nx     = idx;
        an_nx      = an;
        ddp_nx     = dec_ddp;
        frame_done = 1'b0;
        if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) begin
            state_nx = DRIVE;
            cnt_nx   = '0;
            an_nx    = lit ? ~(8'h80 >> idx) : 8'hFF;
            ddp_nx   = lit ? ~{SEG[word[4:1]], word[0]} : 8'hFF;
        end else if (state == DRIVE && cnt == CW'(DIGIT_CYCLES - 1)) begin
            state_nx   = BLANK;
            cnt_nx     = '0;
            idx_nx     = idx + 1'b1;
            an_nx      = 8'hFF;
            ddp_nx     = 8'hFF;
            frame_done = idx == 3'd7;
        end
    end
endmodule

// File: tb/tb_dspl_scan_driver.sv
// tb_dspl_scan_driver: directed checks of scan timing, decode, disable, sampling, reset, blink
module tb_dspl_scan_driver;
    localparam int DC = 10, BC = 2, SLOT = 12, FRAME = 96;
    logic clock = 1'b0, reset = 1'b0;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] blink;
    logic [7:0] an, dec_ddp;
    int cyc = 0, tests = 0, fails = 0;
    logic [7:0] exp_ddp [8];
    logic exp_en [8];

    dspl_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(2)) dut (
        .clock(clock), .reset(reset),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .blink(blink), .an(an), .dec_ddp(dec_ddp)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= reset ? cyc + 1 : 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_an", an, 8'hFF);
        check("rst_ddp", dec_ddp, 8'hFF);
        reset = 1'b1;
    endtask

    task all_zero();
        {d1, d2, d3, d4, d5, d6, d7, d8} = {8{6'b100000}};
        for (int i = 0; i < 8; i++) begin
            exp_ddp[i] = 8'h03;
            exp_en[i]  = 1'b1;
        end
    endtask

    task check_frame(input int start);
        logic [7:0] sel;
        int p, k;
        bit on;
        for (int n = start; n < start + FRAME; n++) begin
            wait_cyc(n);
            p   = n % SLOT;
            k   = (n / SLOT) % 8;
            on  = p >= BC && exp_en[k];
            sel = 8'h80 >> k;
            check($sformatf("an n=%0d", n), an, on ? ~sel : 8'hFF);
            check($sformatf("ddp n=%0d", n), dec_ddp, on ? exp_ddp[k] : 8'hFF);
        end
    endtask

    initial begin
        blink = 8'h00;
        all_zero();
        @(negedge clock);
        // basic scan of all zeros
        do_reset();
        check_frame(1);
        wait_cyc(98);
        check("wrap_an", an, 8'h7F);
        check("wrap_ddp", dec_ddp, 8'h03);
        // decode patterns and a disabled digit
        @(negedge clock);
        d1 = 6'b110001; d2 = 6'b100010; d3 = 6'b110100; d4 = 6'b000000;
        exp_ddp[0] = 8'h00; exp_ddp[1] = 8'h9F; exp_ddp[2] = 8'h11; exp_en[3] = 1'b0;
        do_reset();
        check_frame(1);
        // input change mid-DRIVE is deferred to next slot
        @(negedge clock);
        all_zero();
        do_reset();
        wait_cyc(6);
        d1 = 6'b101010;
        for (int n = 6; n < 12; n++) begin
            wait_cyc(n);
            check($sformatf("hold n=%0d", n), dec_ddp, 8'h03);
        end
        wait_cyc(98);
        check("new_an", an, 8'h7F);
        check("new_ddp", dec_ddp, 8'h49);
        // asynchronous reset during d6 DRIVE
        @(negedge clock);
        all_zero();
        do_reset();
        wait_cyc(65);
        check("d6_an", an, 8'hFB);
        #2 reset = 1'b0;
        #1 check("arst_an", an, 8'hFF);
        check("arst_ddp", dec_ddp, 8'hFF);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_cyc(1);
        check("rel1_an", an, 8'hFF);
        wait_cyc(2);
        check("rel2_an", an, 8'h7F);
        check("rel2_ddp", dec_ddp, 8'h03);
        // blink behaviour
        @(negedge clock);
`ifdef DSPL_BLINK_EN
        blink = 8'h01;
`else
        blink = 8'hFF;
`endif
        do_reset();
        for (int f = 0; f < 6; f++) begin
            wait_cyc(FRAME * f + 2);
`ifdef DSPL_BLINK_EN
            check($sformatf("blink_d1 f=%0d", f), an, (f == 2 || f == 3) ? 8'hFF : 8'h7F);
`else
            check($sformatf("blink_d1 f=%0d", f), an, 8'h7F);
`endif
            wait_cyc(FRAME * f + 14);
            check($sformatf("blink_d2 f=%0d", f), an, 8'hBF);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
